// File: rtl/amiga_kbd_pkg.sv
// Shared constants and enumerations for the Amiga keyboard handshake queue.
package amiga_kbd_pkg;

  // Protocol keycodes generated by the sequencer itself
  localparam logic [7:0] KC_INIT_POWERUP = 8'hFD;
  localparam logic [7:0] KC_TERM_POWERUP = 8'hFE;
  localparam logic [7:0] KC_BUF_OVERFLOW = 8'hFA;
  localparam logic [7:0] KC_LOST_SYNC    = 8'hF9;

  // Origin of the code currently outstanding on the serial link
  typedef enum logic [2:0] {
    SRC_INIT1 = 3'd0,
    SRC_INIT2 = 3'd1,
    SRC_OVF   = 3'd2,
    SRC_FIFO  = 3'd3,
    SRC_LSYNC = 3'd4
  } kbd_src_e;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_INIT_FD  = 3'd0,
    ST_INIT_FE  = 3'd1,
    ST_IDLE     = 3'd2,
    ST_WAIT_ACK = 3'd3,
    ST_RESYNC   = 3'd4
  } kbd_state_e;

endpackage

// File: rtl/amiga_kbd_fifo.sv
// Synchronous keycode FIFO. A push into a full FIFO is ignored unless a pop
// happens on the same edge, in which case both are performed.
module amiga_kbd_fifo #(
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [7:0]    push_data,
  input  logic          pop,
  output logic [7:0]    head,
  output logic [CW-1:0] count,
  output logic          full
);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok_s;
  logic          pop_ok_s;

  // Qualify push/pop and compute next pointers and occupancy
  always_comb begin
    pop_ok_s  = pop && (count_q != '0);
    push_ok_s = push && ((count_q != CW'(DEPTH)) || pop_ok_s);

    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (push_ok_s && !pop_ok_s) begin
      count_d = count_q + CW'(1);
    end else if (pop_ok_s && !push_ok_s) begin
      count_d = count_q - CW'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write; contents need no reset since the pointers define validity
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == CW'(DEPTH));

endmodule

// File: rtl/amiga_kbd_handshake_queue.sv
// Keycode queue and Amiga keyboard protocol sequencer: buffers incoming
// keycodes, releases one at a time, waits for the CIA-A handshake and handles
// power-up codes, overflow reporting and lost-sync recovery.
module amiga_kbd_handshake_queue
  import amiga_kbd_pkg::*;
#(
  parameter  int unsigned DEPTH         = 8,
  parameter  int unsigned TIMEOUT_TICKS = 1013000,
  localparam int unsigned TW            = $clog2(TIMEOUT_TICKS + 1),
  localparam int unsigned CW            = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clk7_en,
  input  logic          in_strobe,
  input  logic [7:0]    in_data,
  input  logic          keyack,
  output logic          out_strobe,
  output logic [7:0]    out_data,
  output logic          busy,
  output logic [CW-1:0] fifo_count,
  output logic          lost_sync
);

  kbd_state_e    state_q, state_d;
  logic [7:0]    cur_code_q, cur_code_d;
  kbd_src_e      cur_src_q, cur_src_d;
  logic [7:0]    retry_code_q, retry_code_d;
  kbd_src_e      retry_src_q, retry_src_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          out_strobe_q, out_strobe_d;
  logic [7:0]    out_data_q, out_data_d;
  logic          busy_q, busy_d;
  logic          lost_sync_q, lost_sync_d;
  logic          ovf_pend_q, ovf_pend_d;

  logic          push_s;
  logic          pop_s;
  logic          issue_s;
  logic [7:0]    issue_code_s;
  kbd_src_e      issue_src_s;
  logic [7:0]    fifo_head_s;
  logic [CW-1:0] fifo_cnt_s;
  logic          fifo_full_s;

  assign push_s = clk7_en && in_strobe;

  amiga_kbd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_s),
    .push_data (in_data),
    .pop       (pop_s),
    .head      (fifo_head_s),
    .count     (fifo_cnt_s),
    .full      (fifo_full_s)
  );

  // Sequencer next-state: decide issue/ack/timeout on each enabled tick
  always_comb begin
    state_d      = state_q;
    cur_code_d   = cur_code_q;
    cur_src_d    = cur_src_q;
    retry_code_d = retry_code_q;
    retry_src_d  = retry_src_q;
    timer_d      = timer_q;
    out_strobe_d = out_strobe_q;
    out_data_d   = out_data_q;
    busy_d       = busy_q;
    lost_sync_d  = lost_sync_q;
    ovf_pend_d   = ovf_pend_q;
    pop_s        = 1'b0;
    issue_s      = 1'b0;
    issue_code_s = 8'h00;
    issue_src_s  = SRC_FIFO;

    if (clk7_en) begin
      // The strobe lasts exactly one enable period unless re-issued below
      out_strobe_d = 1'b0;

      case (state_q)
        ST_INIT_FD: begin
          issue_s      = 1'b1;
          issue_code_s = KC_INIT_POWERUP;
          issue_src_s  = SRC_INIT1;
        end
        ST_INIT_FE: begin
          issue_s      = 1'b1;
          issue_code_s = KC_TERM_POWERUP;
          issue_src_s  = SRC_INIT2;
        end
        ST_IDLE: begin
          if (ovf_pend_q) begin
            issue_s      = 1'b1;
            issue_code_s = KC_BUF_OVERFLOW;
            issue_src_s  = SRC_OVF;
          end else if (fifo_cnt_s != '0) begin
            issue_s      = 1'b1;
            issue_code_s = fifo_head_s;
            issue_src_s  = SRC_FIFO;
          end else begin
            issue_s = 1'b0;
          end
        end
        ST_WAIT_ACK: begin
          if (keyack) begin
            // Any acknowledged code other than 0xF9 ends a resync episode
            if (cur_src_q != SRC_LSYNC) begin
              lost_sync_d = 1'b0;
            end else begin
              lost_sync_d = lost_sync_q;
            end
            case (cur_src_q)
              SRC_INIT1: begin
                state_d = ST_INIT_FE;
              end
              SRC_LSYNC: begin
                state_d = ST_RESYNC;
              end
              SRC_FIFO: begin
                pop_s   = 1'b1;
                state_d = ST_IDLE;
                busy_d  = 1'b0;
              end
              SRC_OVF: begin
                ovf_pend_d = 1'b0;
                state_d    = ST_IDLE;
                busy_d     = 1'b0;
              end
              default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
              end
            endcase
          end else if (timer_q == '0) begin
            lost_sync_d = 1'b1;
            // Keep the original code when 0xF9 itself times out
            if (cur_src_q != SRC_LSYNC) begin
              retry_code_d = cur_code_q;
              retry_src_d  = cur_src_q;
            end else begin
              retry_code_d = retry_code_q;
              retry_src_d  = retry_src_q;
            end
            issue_s      = 1'b1;
            issue_code_s = KC_LOST_SYNC;
            issue_src_s  = SRC_LSYNC;
          end else begin
            timer_d = timer_q - TW'(1);
          end
        end
        ST_RESYNC: begin
          issue_s      = 1'b1;
          issue_code_s = retry_code_q;
          issue_src_s  = retry_src_q;
        end
        default: begin
          state_d = ST_INIT_FD;
        end
      endcase

      if (issue_s) begin
        cur_code_d   = issue_code_s;
        cur_src_d    = issue_src_s;
        out_data_d   = issue_code_s;
        out_strobe_d = 1'b1;
        timer_d      = TW'(TIMEOUT_TICKS);
        busy_d       = 1'b1;
        state_d      = ST_WAIT_ACK;
      end else begin
        state_d = state_d;
      end

      // A dropped keycode must be reported even if 0xFA is acked this tick
      if (in_strobe && fifo_full_s && !pop_s) begin
        ovf_pend_d = 1'b1;
      end else begin
        ovf_pend_d = ovf_pend_d;
      end
    end else begin
      state_d = state_q;
    end
  end

  // Sequencer registers, including all registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_INIT_FD;
      cur_code_q   <= 8'h00;
      cur_src_q    <= SRC_INIT1;
      retry_code_q <= 8'h00;
      retry_src_q  <= SRC_INIT1;
      timer_q      <= '0;
      out_strobe_q <= 1'b0;
      out_data_q   <= 8'h00;
      busy_q       <= 1'b0;
      lost_sync_q  <= 1'b0;
      ovf_pend_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_code_q   <= cur_code_d;
      cur_src_q    <= cur_src_d;
      retry_code_q <= retry_code_d;
      retry_src_q  <= retry_src_d;
      timer_q      <= timer_d;
      out_strobe_q <= out_strobe_d;
      out_data_q   <= out_data_d;
      busy_q       <= busy_d;
      lost_sync_q  <= lost_sync_d;
      ovf_pend_q   <= ovf_pend_d;
    end
  end

  assign out_strobe = out_strobe_q;
  assign out_data   = out_data_q;
  assign busy       = busy_q;
  assign fifo_count = fifo_cnt_s;
  assign lost_sync  = lost_sync_q;

endmodule

// File: tb/tb_amiga_kbd_handshake_queue.sv
// Self-checking bench: directed protocol scenarios followed by random traffic,
// every enabled tick compared against a transaction-level protocol model.
module tb_amiga_kbd_handshake_queue;

  localparam int DEPTH = 8;
  localparam int TO    = 20;

  localparam int K_INIT1 = 0;
  localparam int K_INIT2 = 1;
  localparam int K_OVF   = 2;
  localparam int K_FIFO  = 3;
  localparam int K_LSYNC = 4;

  logic       clk       = 1'b0;
  logic       reset     = 1'b1;
  logic       clk7_en   = 1'b0;
  logic       in_strobe = 1'b0;
  logic [7:0] in_data   = 8'h00;
  logic       keyack    = 1'b0;
  logic       out_strobe;
  logic [7:0] out_data;
  logic       busy;
  logic [3:0] fifo_count;
  logic       lost_sync;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int         q[$];
  bit         m_ovf;
  bit         m_act;
  logic [7:0] m_code;
  int         m_kind;
  int         m_age;
  int         m_stage;
  bit         m_resync;
  logic [7:0] m_sv_code;
  int         m_sv_kind;
  bit         m_lsync;
  bit         m_busy;
  bit         m_strobe;
  logic [7:0] m_data;

  amiga_kbd_handshake_queue #(.DEPTH(DEPTH), .TIMEOUT_TICKS(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .clk7_en    (clk7_en),
    .in_strobe  (in_strobe),
    .in_data    (in_data),
    .keyack     (keyack),
    .out_strobe (out_strobe),
    .out_data   (out_data),
    .busy       (busy),
    .fifo_count (fifo_count),
    .lost_sync  (lost_sync)
  );

  always #5 clk = ~clk;

  // Enable on every other clock edge
  always @(negedge clk) clk7_en <= ~clk7_en;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf = 0; m_act = 0; m_code = 8'h00; m_kind = K_INIT1; m_age = 0;
    m_stage = 0; m_resync = 0; m_sv_code = 8'h00; m_sv_kind = K_INIT1;
    m_lsync = 0; m_busy = 0; m_strobe = 0; m_data = 8'h00;
  endtask

  task automatic m_issue(input logic [7:0] c, input int k);
    m_act = 1; m_code = c; m_kind = k; m_age = 0;
    m_strobe = 1; m_data = c; m_busy = 1;
  endtask

  // One enabled tick of the protocol, expressed as transactions
  task automatic model_tick(input bit s, input logic [7:0] d, input bit a);
    m_strobe = 0;
    if (m_act) begin
      m_age++;
      if (a) begin
        m_act = 0;
        if (m_kind != K_LSYNC) m_lsync = 0;
        case (m_kind)
          K_INIT1: m_stage = 1;
          K_INIT2: begin m_stage = 2; m_busy = 0; end
          K_OVF:   begin m_ovf = 0; m_busy = 0; end
          K_FIFO:  begin void'(q.pop_front()); m_busy = 0; end
          default: m_resync = 1;
        endcase
      end else if (m_age == TO + 1) begin
        m_lsync = 1;
        if (m_kind != K_LSYNC) begin m_sv_code = m_code; m_sv_kind = m_kind; end
        m_issue(8'hF9, K_LSYNC);
      end
    end else if (m_resync) begin
      m_resync = 0;
      m_issue(m_sv_code, m_sv_kind);
    end else if (m_stage == 0) begin
      m_issue(8'hFD, K_INIT1);
    end else if (m_stage == 1) begin
      m_issue(8'hFE, K_INIT2);
    end else if (m_ovf) begin
      m_issue(8'hFA, K_OVF);
    end else if (q.size() > 0) begin
      m_issue(8'(q[0]), K_FIFO);
    end
    if (s) begin
      if (q.size() < DEPTH) q.push_back(int'(d));
      else m_ovf = 1;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_strobe"}, 32'(out_strobe), 32'(m_strobe));
    chk({tag, "_data"}, 32'(out_data), 32'(m_data));
    chk({tag, "_busy"}, 32'(busy), 32'(m_busy));
    chk({tag, "_lsync"}, 32'(lost_sync), 32'(m_lsync));
    chk({tag, "_count"}, 32'(fifo_count), 32'(q.size()));
  endtask

  task automatic step(input bit s, input logic [7:0] d, input bit a);
    in_strobe = s; in_data = d; keyack = a;
    do @(posedge clk); while (clk7_en !== 1'b1);
    #1;
    in_strobe = 1'b0; in_data = 8'h00; keyack = 1'b0;
    model_tick(s, d, a);
    check_all("tick");
  endtask

  // Acknowledge whatever is outstanding, tick by tick
  task automatic serve(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, m_act);
  endtask

  task automatic do_reset();
    in_strobe = 1'b0; keyack = 1'b0; in_data = 8'h00;
    reset = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    model_reset();
    chk("rst_strobe", 32'(out_strobe), 32'h0);
    chk("rst_data", 32'(out_data), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_count", 32'(fifo_count), 32'h0);
    chk("rst_lsync", 32'(lost_sync), 32'h0);
    reset = 1'b0;
  endtask

  initial begin
    model_reset();
    do_reset();

    // Power-up sequence
    step(1'b0, 8'h00, 1'b0);
    chk("pwr_fd", {23'h0, out_strobe, out_data}, {23'h0, 1'b1, 8'hFD});
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);
    chk("pwr_fe", {23'h0, out_strobe, out_data}, {23'h0, 1'b1, 8'hFE});
    step(1'b0, 8'h00, 1'b1);
    chk("pwr_busy", 32'(busy), 32'h0);

    // Queue ordering
    step(1'b1, 8'h45, 1'b0);
    step(1'b1, 8'hC5, 1'b0);
    chk("q_45", {23'h0, out_strobe, out_data}, {23'h0, 1'b1, 8'h45});
    step(1'b1, 8'h10, 1'b0);
    chk("q_cnt3", 32'(fifo_count), 32'd3);
    step(1'b0, 8'h00, 1'b1);
    chk("q_cnt2", 32'(fifo_count), 32'd2);
    step(1'b0, 8'h00, 1'b0);
    chk("q_c5", {23'h0, out_strobe, out_data}, {23'h0, 1'b1, 8'hC5});
    step(1'b0, 8'h00, 1'b1);
    chk("q_cnt1", 32'(fifo_count), 32'd1);
    step(1'b0, 8'h00, 1'b0);
    chk("q_10", {23'h0, out_strobe, out_data}, {23'h0, 1'b1, 8'h10});
    step(1'b0, 8'h00, 1'b1);
    chk("q_cnt0", 32'(fifo_count), 32'd0);

    // Stray keyack in IDLE
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 8'h00, 1'b1);
      chk("stray_strobe", 32'(out_strobe), 32'h0);
    end

    // Overflow: nine pushes without acks
    for (int i = 1; i <= 9; i++) step(1'b1, 8'(i), 1'b0);
    chk("ovf_cnt8", 32'(fifo_count), 32'd8);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);
    chk("ovf_fa", {23'h0, out_strobe, out_data}, {23'h0, 1'b1, 8'hFA});
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);
    chk("ovf_head", {23'h0, out_strobe, out_data}, {23'h0, 1'b1, 8'h02});
    serve(30);

    // Lost sync and retransmission
    step(1'b1, 8'h33, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    chk("ls_33", {23'h0, out_strobe, out_data}, {23'h0, 1'b1, 8'h33});
    for (int i = 0; i < TO; i++) begin
      step(1'b0, 8'h00, 1'b0);
      chk("ls_quiet", 32'(out_strobe), 32'h0);
    end
    step(1'b0, 8'h00, 1'b0);
    chk("ls_f9", {22'h0, lost_sync, out_strobe, out_data}, {22'h0, 1'b1, 1'b1, 8'hF9});
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);
    chk("ls_re33", {23'h0, out_strobe, out_data}, {23'h0, 1'b1, 8'h33});
    step(1'b0, 8'h00, 1'b1);
    chk("ls_clear", {27'h0, lost_sync, fifo_count}, {27'h0, 1'b0, 4'd0});

    // keyack coincident with timeout counts as ack
    step(1'b1, 8'h55, 1'b0);
    for (int i = 0; i < TO + 1; i++) step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    chk("coin_ack", {26'h0, out_strobe, lost_sync, fifo_count}, {26'h0, 1'b0, 1'b0, 4'd0});
    step(1'b0, 8'h00, 1'b0);
    chk("coin_nof9", 32'(out_strobe), 32'h0);

    // Timeout on 0xF9 reissues 0xF9 and keeps the saved code
    step(1'b1, 8'h66, 1'b0);
    for (int i = 0; i < 2 * (TO + 1) + 1; i++) step(1'b0, 8'h00, 1'b0);
    chk("f9_retry", {22'h0, lost_sync, out_strobe, out_data}, {22'h0, 1'b1, 1'b1, 8'hF9});
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);
    chk("f9_re66", {23'h0, out_strobe, out_data}, {23'h0, 1'b1, 8'h66});
    serve(4);

    // Reset in WAIT_ACK with three queued codes
    step(1'b1, 8'hA1, 1'b0);
    step(1'b1, 8'hA2, 1'b0);
    step(1'b1, 8'hA3, 1'b0);
    chk("mr_cnt3", 32'(fifo_count), 32'd3);
    do_reset();
    step(1'b0, 8'h00, 1'b0);
    chk("mr_fd", {23'h0, out_strobe, out_data}, {23'h0, 1'b1, 8'hFD});
    serve(6);

    // Random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      bit s;
      bit a;
      s = ($urandom_range(0, 99) < 30);
      a = m_act ? ($urandom_range(0, 99) < 12) : ($urandom_range(0, 99) < 5);
      step(s, 8'($urandom_range(0, 255)), a);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/amiga_kbd_handshake_queue.md
# amiga_kbd_handshake_queue

Keycode queue and Amiga keyboard-protocol sequencer upstream of `amiga_keyboard`'s key transmitter. It buffers raw Amiga keycodes from the PS/2 or MiST decoder in an 8-entry FIFO, and releases them one at a time as a strobe/data pair. It waits for the CIA-A serial handshake (`keyack`) before releasing the next code, and implements the Amiga keyboard protocol's:
- power-up codes (0xFD, 0xFE);
- buffer-overflow report (0xFA);
- lost-sync recovery (0xF9 then retransmit).

## Interface
- `DEPTH`, 8: FIFO entries, power of two.
- `TIMEOUT_TICKS`, 1013000: clk7_en ticks to wait for `keyack` (143 ms at 7.09 MHz); benches override it small.
- `clk` in 1: system clock. One clock domain.
- `reset` in 1: reset, synchronous, active-high.
- `clk7_en` in 1: 7 MHz enable. All state changes happen only on edges with `clk7_en`=1.
- `in_strobe` in 1: keycode valid. Sampled only when `clk7_en`=1.
- `in_data` in 8: raw Amiga keycode, bit7 = key-up. No rotation or inversion.
- `keyack` in 1: handshake pulse from the CIA-A SP line. Sampled only when `clk7_en`=1.
- `out_strobe` out 1: code valid to the transmitter stage.
- `out_data` out 8: raw code. The rotate and invert are done downstream.
- `busy` out 1: high while a code is outstanding.
- `fifo_count` out 4: current FIFO occupancy, range 0..DEPTH.
- `lost_sync` out 1: high from a timeout until the retransmitted code is acknowledged.

## Operation
- **State machine:** states are INIT_FD, INIT_FE, IDLE, WAIT_ACK and RESYNC. Reset enters INIT_FD.
- **INIT_FD / INIT_FE:** on the first enabled edge, issue 0xFD and go to WAIT_ACK (source INIT1). When the 0xFD ack arrives, go to INIT_FE. INIT_FE issues 0xFE (source INIT2). Its ack leads to IDLE.
- **Issue action:** load `cur_code` and `cur_src`, set `out_data`=`cur_code` and `out_strobe`=1, load the timer with `TIMEOUT_TICKS`, and set `busy`=1.
- **IDLE priority:**
  1. if `ovf_pend`, issue 0xFA (source OVF);
  2. else if `fifo_count`>0, issue the FIFO head (source FIFO);
  3. else stay in IDLE.
- **WAIT_ACK on `keyack`:**
  - source FIFO: pop the head;
  - source OVF: clear `ovf_pend`;
  - source LSYNC: go to RESYNC;
  - otherwise: go to IDLE (or to INIT_FE, as above).
  - `busy` goes to 0 when IDLE is re-entered.
- **WAIT_ACK timeout** (timer reaches 0, no `keyack`):
  - set `lost_sync`;
  - save `cur_code`/`cur_src` in a retry register;
  - issue 0xF9 with source LSYNC.
  - A timeout on 0xF9 itself reissues 0xF9 and leaves the saved code untouched. Retries repeat indefinitely.
- **RESYNC:** reissue the saved code and source, go to WAIT_ACK, and clear `lost_sync` when that code's ack arrives.
- **Pop timing:** the FIFO head is popped only on ack, never on issue, so a retransmitted code is always the same head.
- **Push:** on `in_strobe`, push if `fifo_count`<DEPTH. If full, drop `in_data` and set `ovf_pend`.
- **Simultaneous push and pop:** when full, the push is accepted and the count is unchanged.
- **Stray `keyack`:** ignored outside WAIT_ACK.
- **Mid-operation reset:** the FIFO is emptied, `ovf_pend` and the timer are cleared, and the init sequence restarts.

## Timing
- **Reset values:** `out_strobe`=0, `out_data`=0x00, `busy`=0, `fifo_count`=0, `lost_sync`=0.
- **`out_strobe` width:** set on an enabled edge and cleared on the next enabled edge, i.e. exactly one enable period.
- **Latency, empty FIFO:** `in_strobe` at enabled edge E0 is pushed at E0. The issue happens at E1, so `out_strobe` is high E1..E2.
- **Next code after an ack:** `keyack` at edge Ek moves the FSM to IDLE. The next issue happens at Ek+1.
- **Timeout:** the timer decrements once per enabled tick in WAIT_ACK. Timeout fires on the enabled edge where the timer equals 0, i.e. exactly `TIMEOUT_TICKS`+1 ticks after the issue.
- **Ack vs. timeout:** when `keyack` and timeout fall on the same edge, ack wins.
- **Timer width:** 20 bits, sized by `$clog2(TIMEOUT_TICKS+1)`.

## Structure
- **Shared package `amiga_kbd_pkg`:**
  - constants: `KC_INIT_POWERUP`=0xFD, `KC_TERM_POWERUP`=0xFE, `KC_BUF_OVERFLOW`=0xFA, `KC_LOST_SYNC`=0xF9;
  - the source enum: INIT1, INIT2, OVF, FIFO, LSYNC;
  - the FSM state enum.
- **Sub-module:** one, `amiga_kbd_fifo` (sync FIFO with push/pop/count, full-push ignored).

## Test plan
- **Power-up:** release reset with no `keyack`.
  - Expect 0xFD on the first enabled edge.
  - Ack it and expect 0xFE one tick later.
  - Ack it; `busy`=0.
- **Queue ordering:** push 0x45, 0xC5, 0x10 back-to-back while 0x45 is unacknowledged.
  - Each code comes out only after an ack, in order.
  - `fifo_count` reads 3→2→1→0 on successive acks.
- **Overflow:** with no acks, push 9 codes into DEPTH=8.
  - `fifo_count`=8 and the 9th code is dropped.
  - After the current ack, 0xFA is issued before the FIFO head.
- **Lost sync:** with `TIMEOUT_TICKS`=20, issue 0x33 and withhold `keyack`.
  - 0xF9 appears 21 ticks after the issue and `lost_sync`=1.
  - Ack it; 0x33 is reissued.
  - Ack that; `lost_sync`=0 and 0x33 is popped once.
- **Edge cases:**
  - `keyack` coincident with timeout counts as an ack, with no 0xF9.
  - A stray `keyack` in IDLE has no effect.
  - Reset asserted in WAIT_ACK with 3 queued codes gives `fifo_count`=0, and 0xFD is re-sent.
